// File: rtl/pam4_thermo_decoder.sv
// rtl/pam4_thermo_decoder.sv - PAM4 thermometer receiver: sync, per-bit majority vote, decode, pack
module pam4_thermo_decoder #(
    parameter int OSR       = 4,
    parameter int WORD_SYMS = 4,
    parameter int ERR_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             thermo_in,
    input  logic                   sym_align,
    input  logic                   err_clr,
    output logic [1:0]             sym_out,
    output logic                   sym_valid,
    output logic [2*WORD_SYMS-1:0] data_out,
    output logic                   data_valid,
    output logic                   code_err,
    output logic [ERR_W-1:0]       err_count
);

    localparam int CNT_W  = $clog2(OSR + 1);
    localparam int CNT_W1 = CNT_W + 1;
    localparam int PH_W   = $clog2(OSR);
    localparam int PC_W   = (WORD_SYMS > 1) ? $clog2(WORD_SYMS) : 1;
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OSR - 1);
    localparam logic [CNT_W:0]   OSR_V   = CNT_W1'(OSR);
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(WORD_SYMS - 1);

    logic [2:0]                   sync1_q, sync2_q;
    logic [1:0]                   vld_q;
    logic [PH_W-1:0]              ph_q, ph_d;
    logic [2:0][CNT_W-1:0]        cnt_q, cnt_d, tot;
    logic [PC_W-1:0]              pc_q, pc_d;
    logic [2*WORD_SYMS-1:0]       sr_q, sr_d, data_q, data_d, shifted;
    logic [1:0]                   sym_q, sym_d;
    logic                         symv_q, symv_d, err_q, err_d, dv_q, dv_d;
    logic [ERR_W-1:0]             ecnt_q, ecnt_d;

    logic                         first, last, bubble;
    logic [2:0]                   voted;
    logic [1:0]                   pop, dec_sym;

    // Vote and decode the symbol that completes with the current sample.
    always_comb begin
        first = sym_align || (ph_q == '0);
        last  = !sym_align && (ph_q == PH_LAST);
        tot   = '0;
        voted = '0;
        for (int i = 0; i < 3; i++) begin
            tot[i]   = (first ? '0 : cnt_q[i]) + CNT_W'(sync2_q[i]);
            voted[i] = ({tot[i], 1'b0} > OSR_V);
        end
        pop = {1'b0, voted[0]} + {1'b0, voted[1]} + {1'b0, voted[2]};
        // Valid thermometer codes map to 3-popcount as well, so one rule covers both.
        dec_sym = ~pop;
        case (voted)
            3'b111, 3'b011, 3'b001, 3'b000: bubble = 1'b0;
            default:                        bubble = 1'b1;
        endcase
        shifted      = sr_q << 2;
        shifted[1:0] = dec_sym;
    end

    always_comb begin
        ph_d   = ph_q;
        cnt_d  = cnt_q;
        pc_d   = pc_q;
        sr_d   = sr_q;
        data_d = data_q;
        sym_d  = sym_q;
        symv_d = 1'b0;
        err_d  = 1'b0;
        dv_d   = 1'b0;
        // Nothing advances until the synchronizer holds real samples.
        if (vld_q[1]) begin
            cnt_d = tot;
            if (sym_align) begin
                pc_d = '0;
            end
            if (last) begin
                ph_d   = '0;
                sym_d  = dec_sym;
                symv_d = 1'b1;
                err_d  = bubble;
                sr_d   = shifted;
                if (pc_q == PC_LAST) begin
                    data_d = shifted;
                    dv_d   = 1'b1;
                    pc_d   = '0;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end else begin
                ph_d = sym_align ? PH_W'(1) : ph_q + PH_W'(1);
            end
        end

        ecnt_d = ecnt_q;
        if (err_clr) begin
            ecnt_d = '0;
        end else if (err_q && (ecnt_q != '1)) begin
            ecnt_d = ecnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            vld_q   <= '0;
            ph_q    <= '0;
            cnt_q   <= '0;
            pc_q    <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            sym_q   <= '0;
            symv_q  <= 1'b0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            sync1_q <= thermo_in;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            sym_q   <= sym_d;
            symv_q  <= symv_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign sym_out    = sym_q;
    assign sym_valid  = symv_q;
    assign data_out   = data_q;
    assign data_valid = dv_q;
    assign code_err   = err_q;
    assign err_count  = ecnt_q;

endmodule

// File: doc/pam4_thermo_decoder.md
Name: pam4_thermo_decoder

Overview:
- Receive-side counterpart of the PAM4 thermometer encoder.
- Takes the 3-bit comparator (thermometer) outputs from the optical/RGB receiver front end, oversampled at clk.
- Per bit, majority-votes across each symbol period, maps the voted code back to a 2-bit symbol, corrects bubble (non-thermometer) codes, and packs symbols into words with valid strobes.
- Also maintains a saturating code-error counter for link-quality monitoring.

Parameters:
- OSR, 4, clk samples per PAM4 symbol (>=2).
- WORD_SYMS, 4, symbols packed per output word (>=1).
- ERR_W, 16, width of the error counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- thermo_in  input  3  raw comparator outputs, asynchronous to clk.
- sym_align  input  1  pulse: the current synchronized sample is phase 0 of a new symbol.
- err_clr  input  1  pulse: clear err_count.
- sym_out  output  2  last decoded symbol.
- sym_valid  output  1  one-cycle strobe when sym_out updates.
- data_out  output  2*WORD_SYMS  packed word; first-received symbol in the MSBs.
- data_valid  output  1  one-cycle strobe when data_out updates.
- code_err  output  1  one-cycle strobe, coincident with sym_valid, when the voted code was invalid.
- err_count  output  ERR_W  saturating count of invalid voted codes.

Behaviour:
- Reset: all outputs are 0. Synchronizer flops, phase counter, vote accumulators and pack counter are also 0.
- Synchronizer: thermo_in passes through 2 flops (sync). Only sync feeds the logic.
- Phase counter `ph` runs 0..OSR-1 and wraps.
  - sym_align forces the current sample to be treated as phase 0: the accumulators restart with that sample and ph becomes 1 next cycle (or wraps to 0 if OSR-1==0 is not allowed; OSR>=2).
  - sym_align also clears the pack counter, discarding any partial word. No strobes are issued for the discarded part.
- Accumulation: per bit i, cnt[i] counts the ones in sync[i] over the OSR samples of the symbol, including the phase OSR-1 sample.
- Vote: at phase OSR-1, v[i] = 1 iff 2*cnt[i] > OSR. Ties (even OSR) resolve to 0.
- Decode of voted code v[2:0]:
  - 111 -> 00
  - 011 -> 01
  - 001 -> 10
  - 000 -> 11
  - Invalid codes 010, 100, 101, 110 use popcount correction: 3 -> 00, 2 -> 01, 1 -> 10, 0 -> 11. code_err is asserted.
- Output timing: sym_out, sym_valid and code_err are registered and assert the cycle after the phase OSR-1 sample.
  - Latency thermo_in to sym_valid = OSR + 2 cycles from the phase 0 input sample (2 sync + OSR accumulate).
- Packing: each decoded symbol shifts into the shift register from the LSB side, so the oldest symbol ends in the MSBs.
  - When the WORD_SYMS-th symbol arrives, data_out updates and data_valid pulses in the same cycle as that sym_valid. The pack counter returns to 0.
  - data_out holds its value between strobes.
- err_count increments by 1 on each code_err and saturates at all-ones.
  - err_clr sets it to 0.
  - err_clr and increment in the same cycle: result is 0 (clear wins).
- Reset mid-operation: next cycle all state is 0. The first symbol after rst deasserts begins at phase 0 of the first synchronized sample, which is the 3rd cycle after deassert.

Test Plan:
- OSR=4, WORD_SYMS=4: hold thermo_in=111, 011, 001, 000 for 4 samples each after sym_align -> sym_out sequence 00, 01, 10, 11, each with a sym_valid pulse 4 cycles apart. data_out=8'b00011011 with data_valid on the 4th sym_valid. code_err never asserts.
- Majority vote: symbol samples 111, 111, 111, 011 -> sym_out=00. Samples 111, 111, 011, 011 -> bit2 tie -> voted 011 -> sym_out=01, no code_err.
- Bubble: hold 101 for one symbol -> sym_out=01, code_err=1, err_count 0 -> 1. Hold 100 -> sym_out=10, err_count=2. Pulse err_clr together with another 110 symbol's code_err -> err_count=0.
- Saturation: ERR_W=2, send 5 invalid symbols -> err_count stops at 3.
- Realign: after 2 symbols of a word, pulse sym_align -> no data_valid for the partial word. The next 4 symbols produce one word containing only those 4 symbols.
- Reset mid-word: assert rst during symbol 3 -> all outputs 0 next cycle. After release, a fresh 4-symbol sequence yields a correct word with no leftover bits.
